shiftadd_seq_ctrl: RTL and testbench
====================================

// Module: shiftadd_seq_ctrl
// PURPOSE
//  Sequencing controller for a shift-add multiplier. It folds the partial-product
//  adder over WIDTH clock cycles, one multiplier bit per cycle.
//  Operands enter through a valid/ready handshake. The product leaves through a
//  valid/ready handshake and is held under backpressure.
//  It sits between an operand producer and a result consumer, in place of the
//  purely combinational multiplier, when area matters more than latency.
// PARAMETERS
//  WIDTH  4  operand width in bits; product is 2*WIDTH bits; also the RUN cycle count
// PORTS
//  clk           in   1        single clock, rising edge
//  rst           in   1        synchronous, active-high reset
//  in_valid      in   1        operands present on multiplicand/multiplier
//  in_ready      out  1        controller can accept operands (IDLE only)
//  multiplicand  in   WIDTH    unsigned operand A
//  multiplier    in   WIDTH    unsigned operand B
//  out_valid     out  1        product valid (DONE only)
//  out_ready     in   1        consumer takes the product
//  product       out  2*WIDTH  unsigned A*B, held while out_valid=1
//  busy          out  1        high in RUN or DONE
// BEHAVIOUR
//  Reset (rst=1 at a clk edge, regardless of state):
//   state=IDLE, counter=0, accumulator=0, product=0, out_valid=0, busy=0.
//   in_ready=1 from the first cycle after reset.
//   Reset mid-RUN or mid-DONE discards the operation; no product is emitted.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: in_ready=1. On in_valid&in_ready at an edge:
//     latch A and B; clear the accumulator and counter; go to RUN.
//   RUN: in_ready=0; in_valid is ignored. At each edge:
//     if B[counter], accumulator += {A} << counter, in 2*WIDTH bits (no overflow possible).
//     counter++.
//     When counter==WIDTH-1 at the edge, go to DONE; product <= final accumulator.
//   DONE: out_valid=1; product is stable. On out_valid&out_ready at an edge, go to IDLE.
//     out_ready low: hold DONE and product indefinitely.
//  Latency: with acceptance at edge E0, out_valid is first high after edge E0+WIDTH.
//   WIDTH=4 gives 4 edges after acceptance. Throughput is one product per WIDTH+2 cycles minimum.
//  No same-cycle accept after hand-off: in_ready rises the cycle after the DONE->IDLE edge.
//  product keeps its last value in IDLE/RUN; it changes only on entry to DONE or on reset.
//  The counter is $clog2(WIDTH)+1 bits wide; it never wraps inside one operation.
//  A=0 or B=0 still takes the full WIDTH RUN cycles (no early exit).
// STRUCTURE
//  Package shiftadd_pkg:
//   state enum {IDLE, RUN, DONE} (2-bit encoding);
//   localparam PROD_W = 2*WIDTH; counter width function.
//  Sub-module shiftadd_step (combinational):
//   inputs: acc, A, bit, shift amount; output: next acc.
//   Instantiated once in the RUN datapath.
//  The top level holds the FSM, counter, operand registers, accumulator and output register.
// TESTING (WIDTH=4)
//  1. Reset, then A=3,B=5, in_valid 1 cycle, out_ready=1
//     -> out_valid after exactly 4 edges post-accept, product=15, in_ready=1 the next cycle.
//  2. A=15,B=15 -> product=225 (8'hE1).
//     A=0,B=9 -> product=0, still 4 RUN cycles.
//  3. Backpressure: out_ready=0 for 10 cycles after out_valid
//     -> product/out_valid held; in_valid pulses meanwhile are not accepted (in_ready=0).
//  4. rst asserted at the 2nd RUN cycle of A=7,B=6
//     -> next cycle IDLE, out_valid=0, product=0; the following op A=2,B=3 yields 6.
//  5. Back-to-back: in_valid held high with out_ready=1 over 3 operand sets
//     -> 3 correct products, each accept separated by WIDTH+2=6 cycles.
//  6. Random sweep of all 256 operand pairs against a reference A*B
//     -> zero mismatches; assertion: out_valid implies state==DONE.

Source files
------------

// File: rtl/shiftadd_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier controller.
package shiftadd_pkg;

  // Default operand width; the product is twice as wide.
  localparam int DEF_WIDTH = 4;
  localparam int PROD_W    = 2 * DEF_WIDTH;

  // Controller states: waiting for operands, folding bits, holding the product.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter needs one spare bit so it can step one past the last bit
  // index without wrapping inside an operation.
  function automatic int cntWidth(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/shiftadd_seq_ctrl_step.sv
// One fold of the shift-add multiplier: conditionally add the shifted
// multiplicand into the running accumulator.
module shiftadd_step #(
  parameter int WIDTH   = 4,
  parameter int SHIFT_W = 3
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_a,
  input  logic               i_bit,
  input  logic [SHIFT_W-1:0] i_shift,
  output logic [2*WIDTH-1:0] o_nextAcc
);

  logic [2*WIDTH-1:0] w_partial;

  // Zero-extend A to product width before shifting so no bits fall off the top.
  always_comb begin
    w_partial = {{WIDTH{1'b0}}, i_a} << i_shift;
    o_nextAcc = i_bit ? (i_acc + w_partial) : i_acc;
  end

endmodule

// File: rtl/shiftadd_seq_ctrl.sv
// Sequencing controller for a shift-add multiplier: accepts operands over a
// valid/ready handshake, folds one multiplier bit per cycle, and presents the
// product over a valid/ready handshake, holding it under backpressure.
module shiftadd_seq_ctrl
  import shiftadd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [WIDTH-1:0]     i_multiplicand,
  input  logic [WIDTH-1:0]     i_multiplier,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [2*WIDTH-1:0]   o_product,
  output logic                 o_busy
);

  localparam int PROD_WIDTH = 2 * WIDTH;
  localparam int CNT_W      = cntWidth(WIDTH);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  state_t                 r_state;
  state_t                 w_nextState;
  logic [CNT_W-1:0]       r_count;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic [PROD_WIDTH-1:0]  r_acc;
  logic [PROD_WIDTH-1:0]  r_product;
  logic [PROD_WIDTH-1:0]  w_nextAcc;
  logic [WIDTH-1:0]       w_bShifted;
  logic                   w_bit;

  // Select the multiplier bit addressed by the counter; shifting avoids an
  // index wider than the operand.
  assign w_bShifted = r_b >> r_count;
  assign w_bit      = w_bShifted[0];

  shiftadd_step #(
    .WIDTH   (WIDTH),
    .SHIFT_W (CNT_W)
  ) u_step (
    .i_acc     (r_acc),
    .i_a       (r_a),
    .i_bit     (w_bit),
    .i_shift   (r_count),
    .o_nextAcc (w_nextAcc)
  );

  // State register; reset always returns to IDLE and abandons any operation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: accept in IDLE, run exactly WIDTH folds, wait for the consumer.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_in_valid)             w_nextState = RUN;
      RUN:     if (r_count == LAST_COUNT)  w_nextState = DONE;
      DONE:    if (i_out_ready)            w_nextState = IDLE;
      default:                             w_nextState = IDLE;
    endcase
  end

  // Handshake and status outputs are pure functions of the state.
  always_comb begin
    o_in_ready  = (r_state == IDLE);
    o_out_valid = (r_state == DONE);
    o_busy      = (r_state == RUN) || (r_state == DONE);
  end

  // Datapath: latch operands on accept, fold one bit per RUN cycle, and only
  // update the product register on the final fold so it stays stable elsewhere.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_a     <= i_multiplicand;
            r_b     <= i_multiplier;
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        RUN: begin
          r_acc   <= w_nextAcc;
          r_count <= r_count + 1'b1;
          if (r_count == LAST_COUNT) begin
            r_product <= w_nextAcc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_product = r_product;

endmodule

// File: tb/tb_shiftadd_seq_ctrl.sv
// Directed testbench for the shift-add multiplier controller (WIDTH=4).
module tb_shiftadd_seq_ctrl;
  import shiftadd_pkg::*;

  logic       clk;
  logic       rst;
  logic       inValid;
  logic       inReady;
  logic [3:0] multiplicand;
  logic [3:0] multiplier;
  logic       outValid;
  logic       outReady;
  logic [7:0] product;
  logic       busy;

  int checks = 0;
  int errors = 0;

  shiftadd_seq_ctrl #(.WIDTH(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_in_valid     (inValid),
    .o_in_ready     (inReady),
    .i_multiplicand (multiplicand),
    .i_multiplier   (multiplier),
    .o_out_valid    (outValid),
    .i_out_ready    (outReady),
    .o_product      (product),
    .o_busy         (busy)
  );

  // Free-running clock with a 10-time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Present one operand pair for a single accepting edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
    multiplicand = a;
    multiplier   = b;
    inValid      = 1'b1;
    tick();
    inValid      = 1'b0;
  endtask

  // Count edges until out_valid rises, bounded so a stuck design cannot hang.
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!outValid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  // Directed sequence of scenarios followed by an exhaustive operand sweep.
  initial begin
    int lat;
    int cyc;
    int accIdx;
    int resIdx;
    bit willAccept;
    int acceptCyc[3];
    logic [3:0] seqA[3];
    logic [3:0] seqB[3];
    logic [7:0] seqP[3];

    rst          = 1'b1;
    inValid      = 1'b0;
    outReady     = 1'b1;
    multiplicand = 4'd0;
    multiplier   = 4'd0;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("rstInReady",  16'(inReady),  16'd1);
    checkOutput("rstOutValid", 16'(outValid), 16'd0);
    checkOutput("rstBusy",     16'(busy),     16'd0);
    checkOutput("rstProduct",  16'(product),  16'd0);

    // Basic op 3*5 with exact latency and next-cycle ready.
    applyStimulus(4'd3, 4'd5);
    checkOutput("runInReady",  16'(inReady),  16'd0);
    checkOutput("runBusy",     16'(busy),     16'd1);
    checkOutput("runOutValid", 16'(outValid), 16'd0);
    waitDone(lat);
    checkOutput("lat3x5",      16'(lat),      16'd4);
    checkOutput("prod3x5",     16'(product),  16'd15);
    checkOutput("doneBusy",    16'(busy),     16'd1);
    tick();
    checkOutput("postInReady", 16'(inReady),  16'd1);
    checkOutput("postOutValid",16'(outValid), 16'd0);
    checkOutput("postHoldProd",16'(product),  16'd15);

    // Maximum operands and zero operand.
    applyStimulus(4'd15, 4'd15);
    waitDone(lat);
    checkOutput("lat15x15",  16'(lat),     16'd4);
    checkOutput("prod15x15", 16'(product), 16'hE1);
    tick();
    applyStimulus(4'd0, 4'd9);
    waitDone(lat);
    checkOutput("lat0x9",  16'(lat),     16'd4);
    checkOutput("prod0x9", 16'(product), 16'd0);
    tick();

    // Backpressure: product held, new operands refused.
    outReady = 1'b0;
    applyStimulus(4'd13, 4'd11);
    waitDone(lat);
    checkOutput("bpLat", 16'(lat), 16'd4);
    for (int i = 0; i < 10; i++) begin
      multiplicand = 4'd1;
      multiplier   = 4'd1;
      inValid      = (i % 2 == 0);
      tick();
      checkOutput("bpOutValid", 16'(outValid), 16'd1);
      checkOutput("bpProduct",  16'(product),  16'd143);
      checkOutput("bpInReady",  16'(inReady),  16'd0);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    tick();
    checkOutput("bpReleaseReady", 16'(inReady),  16'd1);
    checkOutput("bpReleaseBusy",  16'(busy),     16'd0);
    checkOutput("bpReleaseProd",  16'(product),  16'd143);

    // Reset in the second RUN cycle discards the operation.
    applyStimulus(4'd7, 4'd6);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midRstInReady",  16'(inReady),  16'd1);
    checkOutput("midRstOutValid", 16'(outValid), 16'd0);
    checkOutput("midRstBusy",     16'(busy),     16'd0);
    checkOutput("midRstProduct",  16'(product),  16'd0);
    applyStimulus(4'd2, 4'd3);
    waitDone(lat);
    checkOutput("lat2x3",  16'(lat),     16'd4);
    checkOutput("prod2x3", 16'(product), 16'd6);
    tick();

    // Back-to-back operations with in_valid held high.
    seqA[0] = 4'd5;  seqB[0] = 4'd7;  seqP[0] = 8'd35;
    seqA[1] = 4'd12; seqB[1] = 4'd10; seqP[1] = 8'd120;
    seqA[2] = 4'd9;  seqB[2] = 4'd14; seqP[2] = 8'd126;
    cyc    = 0;
    accIdx = 0;
    resIdx = 0;
    multiplicand = seqA[0];
    multiplier   = seqB[0];
    inValid      = 1'b1;
    while (resIdx < 3 && cyc < 100) begin
      willAccept = inReady && inValid;
      tick();
      cyc++;
      if (willAccept) begin
        acceptCyc[accIdx] = cyc;
        accIdx++;
        if (accIdx < 3) begin
          multiplicand = seqA[accIdx];
          multiplier   = seqB[accIdx];
        end else begin
          inValid = 1'b0;
        end
      end
      if (outValid) begin
        checkOutput("b2bProduct", 16'(product), 16'(seqP[resIdx]));
        resIdx++;
      end
    end
    inValid = 1'b0;
    checkOutput("b2bResults", 16'(resIdx), 16'd3);
    checkOutput("b2bAccepts", 16'(accIdx), 16'd3);
    if (accIdx == 3) begin
      checkOutput("b2bGap01", 16'(acceptCyc[1] - acceptCyc[0]), 16'd6);
      checkOutput("b2bGap12", 16'(acceptCyc[2] - acceptCyc[1]), 16'd6);
    end
    tick();

    // Sweep all 256 operand pairs in a scrambled order.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] idx;
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] expProd;
      idx     = 8'((i * 167 + 89) % 256);
      a       = idx[7:4];
      b       = idx[3:0];
      expProd = {4'd0, a} * {4'd0, b};
      applyStimulus(a, b);
      waitDone(lat);
      checkOutput("sweepLat",  16'(lat),     16'd4);
      checkOutput("sweepProd", 16'(product), 16'(expProd));
      checkOutput("validImpliesDone", 16'(outValid && (dut.r_state != DONE)), 16'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
